inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues SRAM fetches, buffers up to two
// returned instructions in a small FIFO and hands them to decode.
// Branch/exception redirects flush the buffer and restart fetch.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
    parameter logic [31:0] EXC_ADDR   = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        de_allowin,
    output logic        fe_valid,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_inst
);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [1:0]  r_buf_cnt;
    logic [31:0] r_pc0, r_inst0;   // head entry
    logic [31:0] r_pc1, r_inst1;   // second entry

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_pop;
    logic        w_write;
    logic [2:0]  w_occ;

    // Redirect selection and handshake terms; exception beats branch.
    always_comb begin
        w_redirect    = exc_valid | br_valid;
        w_redirect_pc = exc_valid ? EXC_ADDR : {br_target[31:2], 2'b00};
        fe_valid      = (r_buf_cnt != 2'd0) & ~w_redirect;
        w_pop         = fe_valid & de_allowin;
        w_write       = r_inflight & ~w_redirect;
        // Occupancy after this edge if nothing new is requested; a pop implies
        // buf_cnt >= 1 so this never underflows.
        w_occ         = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        inst_sram_en  = (r_state == S_RUN) & ~w_redirect & (w_occ < 3'd2);
        inst_sram_addr = r_pc;
        fe_pc         = r_pc0;
        fe_inst       = r_inst0;
    end

    // FSM plus PC and in-flight request tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_ADDR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
        end else begin
            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
            r_inflight <= inst_sram_en;
            if (inst_sram_en)
                r_inflight_pc <= r_pc;
            if (w_redirect)
                r_pc <= w_redirect_pc;
            else if (inst_sram_en)
                r_pc <= r_pc + 32'd4;
        end
    end

    // Two-entry FIFO of {pc, inst}; response in a redirect cycle is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_cnt <= 2'd0;
            r_pc0     <= 32'd0;
            r_inst0   <= 32'd0;
            r_pc1     <= 32'd0;
            r_inst1   <= 32'd0;
        end else if (w_redirect) begin
            r_buf_cnt <= 2'd0;
        end else begin
            case ({w_write, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_pc0   <= r_inflight_pc;
                        r_inst0 <= inst_sram_rdata;
                    end else begin
                        r_pc1   <= r_inflight_pc;
                        r_inst1 <= inst_sram_rdata;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_pc0     <= r_pc1;
                    r_inst0   <= r_inst1;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; new entry lands behind whatever remains.
                    if (r_buf_cnt == 2'd1) begin
                        r_pc0   <= r_inflight_pc;
                        r_inst0 <= inst_sram_rdata;
                    end else begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                        r_pc1   <= r_inflight_pc;
                        r_inst1 <= inst_sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a one-cycle-latency SRAM model
// returning ~addr as the instruction word.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic        de_allowin;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_inst;

    int          chk;
    int          pass;
    logic [31:0] exp_pc;

    inst_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .exc_valid       (exc_valid),
        .de_allowin      (de_allowin),
        .fe_valid        (fe_valid),
        .fe_pc           (fe_pc),
        .fe_inst         (fe_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: word appears the cycle after the request
    always @(posedge clk)
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ 32'hffffffff;

    // Buffer must never overflow
    always @(posedge clk)
        if (!reset) begin
            assert (!(dut.r_inflight && !(br_valid || exc_valid) &&
                      dut.r_buf_cnt == 2'd2 && !(fe_valid && de_allowin)))
                else $error("write into full buffer");
            assert (dut.r_buf_cnt <= 2'd2) else $error("buf_cnt overflow");
        end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next(); next();
        #1;
        chk++; if (inst_sram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", inst_sram_en); else pass++;
        chk++; if (inst_sram_addr !== 32'hbfc00000) $display("FAIL reset_addr: got %h want bfc00000", inst_sram_addr); else pass++;
        chk++; if (fe_valid !== 1'b0) $display("FAIL reset_fe_valid: got %b want 0", fe_valid); else pass++;
        chk++; if (fe_pc !== 32'd0) $display("FAIL reset_fe_pc: got %h want 0", fe_pc); else pass++;
        chk++; if (fe_inst !== 32'd0) $display("FAIL reset_fe_inst: got %h want 0", fe_inst); else pass++;
    endtask

    // Release reset and check the boot sequence plus steady streaming
    task automatic test_boot(input string tag, input int n);
        next();
        reset = 1'b0; de_allowin = 1'b1;
        #1;
        chk++; if (inst_sram_en !== 1'b0) $display("FAIL %s_c0_en: got %b want 0", tag, inst_sram_en); else pass++;
        next(); #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00000)
            $display("FAIL %s_c1_req: got en=%b addr=%h want en=1 addr=bfc00000", tag, inst_sram_en, inst_sram_addr); else pass++;
        next(); #1;
        chk++; if (fe_valid !== 1'b0) $display("FAIL %s_c2_valid: got %b want 0", tag, fe_valid); else pass++;
        next(); #1;
        chk++; if (fe_valid !== 1'b1 || fe_pc !== 32'hbfc00000 || fe_inst !== 32'h403fffff)
            $display("FAIL %s_c3_first: got v=%b pc=%h inst=%h want v=1 pc=bfc00000 inst=403fffff", tag, fe_valid, fe_pc, fe_inst); else pass++;
        exp_pc = 32'hbfc00004;
        for (int i = 0; i < n; i++) begin
            next(); #1;
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL %s_stream%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", tag, i, fe_valid, fe_pc, fe_inst, exp_pc, ~exp_pc); else pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            next();
            de_allowin = 1'b0;
            #1;
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL stall_hold%0d: got v=%b pc=%h want v=1 pc=%h", i, fe_valid, fe_pc, exp_pc); else pass++;
            if (i >= 1) begin
                chk++; if (inst_sram_en !== 1'b0) $display("FAIL stall_en%0d: got %b want 0", i, inst_sram_en); else pass++;
            end
        end
        chk++; if (dut.r_buf_cnt !== 2'd2) $display("FAIL stall_cnt: got %0d want 2", dut.r_buf_cnt); else pass++;
        for (int i = 0; i < 6; i++) begin
            next();
            de_allowin = 1'b1;
            #1;
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL resume%0d: got v=%b pc=%h want v=1 pc=%h", i, fe_valid, fe_pc, exp_pc); else pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_branch();
        next(); de_allowin = 1'b0; #1;
        next(); next();
        br_valid = 1'b1; br_target = 32'h80001237;
        #1;
        chk++; if (dut.r_buf_cnt !== 2'd2) $display("FAIL br_full: got %0d want 2", dut.r_buf_cnt); else pass++;
        chk++; if (fe_valid !== 1'b0 || inst_sram_en !== 1'b0)
            $display("FAIL br_cycle: got v=%b en=%b want v=0 en=0", fe_valid, inst_sram_en); else pass++;
        next();
        br_valid = 1'b0; de_allowin = 1'b1;
        #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h80001234 || fe_valid !== 1'b0)
            $display("FAIL br_target: got en=%b addr=%h v=%b want en=1 addr=80001234 v=0", inst_sram_en, inst_sram_addr, fe_valid); else pass++;
        next(); #1;
        chk++; if (fe_valid !== 1'b0) $display("FAIL br_gap: got %b want 0", fe_valid); else pass++;
        exp_pc = 32'h80001234;
        for (int i = 0; i < 4; i++) begin
            next(); #1;
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL br_stream%0d: got v=%b pc=%h want v=1 pc=%h", i, fe_valid, fe_pc, exp_pc); else pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_exc_priority();
        next();
        br_valid = 1'b1; exc_valid = 1'b1; br_target = 32'h80000000;
        #1;
        chk++; if (fe_valid !== 1'b0) $display("FAIL exc_cycle: got v=%b want 0", fe_valid); else pass++;
        next();
        br_valid = 1'b0; exc_valid = 1'b0;
        #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00380)
            $display("FAIL exc_addr: got en=%b addr=%h want en=1 addr=bfc00380", inst_sram_en, inst_sram_addr); else pass++;
        next();
        exp_pc = 32'hbfc00380;
        for (int i = 0; i < 3; i++) begin
            next(); #1;
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL exc_stream%0d: got v=%b pc=%h want v=1 pc=%h", i, fe_valid, fe_pc, exp_pc); else pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_wrap();
        next();
        br_valid = 1'b1; br_target = 32'hfffffff8;
        #1;
        next();
        br_valid = 1'b0;
        #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hfffffff8)
            $display("FAIL wrap_req0: got en=%b addr=%h want en=1 addr=fffffff8", inst_sram_en, inst_sram_addr); else pass++;
        next(); #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hfffffffc)
            $display("FAIL wrap_req1: got en=%b addr=%h want en=1 addr=fffffffc", inst_sram_en, inst_sram_addr); else pass++;
        next(); #1;
        chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h00000000)
            $display("FAIL wrap_req2: got en=%b addr=%h want en=1 addr=00000000", inst_sram_en, inst_sram_addr); else pass++;
        exp_pc = 32'hfffffff8;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin next(); #1; end
            chk++; if (fe_valid !== 1'b1 || fe_pc !== exp_pc || fe_inst !== ~exp_pc)
                $display("FAIL wrap_stream%0d: got v=%b pc=%h want v=1 pc=%h", i, fe_valid, fe_pc, exp_pc); else pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_async_reset();
        next(); de_allowin = 1'b0; #1;
        next(); next();
        de_allowin = 1'b1;
        #1;
        chk++; if (inst_sram_en !== 1'b1 || dut.r_buf_cnt !== 2'd2)
            $display("FAIL ares_pre: got en=%b cnt=%0d want en=1 cnt=2", inst_sram_en, dut.r_buf_cnt); else pass++;
        #2;
        reset = 1'b1;
        #1;
        chk++; if (inst_sram_en !== 1'b0 || fe_valid !== 1'b0 || inst_sram_addr !== 32'hbfc00000 || fe_pc !== 32'd0)
            $display("FAIL ares_now: got en=%b v=%b addr=%h pc=%h want en=0 v=0 addr=bfc00000 pc=0",
                     inst_sram_en, fe_valid, inst_sram_addr, fe_pc); else pass++;
        next();
        test_boot("restart", 3);
    endtask

    initial begin
        chk = 0; pass = 0; exp_pc = 32'd0;
        reset = 1'b1; br_valid = 1'b0; br_target = 32'd0; exc_valid = 1'b0;
        de_allowin = 1'b0; inst_sram_rdata = 32'd0;
        test_reset();
        test_boot("boot", 6);
        test_stall();
        test_branch();
        test_exc_priority();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
